// File: rtl/latch_mon_pkg.sv
// latch_mon_pkg
//   Shared types and constants for latch_behavior_monitor.
//   - state_t       : monitor FSM states (encoding is visible on the debug port)
//   - ERR_*         : err_code values
//   - settle_cnt_w  : width needed by the settle down-counter to hold SETTLE
package latch_mon_pkg;

  typedef enum logic [2:0] {
    ST_UNKNOWN  = 3'd0,
    ST_T_SETTLE = 3'd1,
    ST_T_STABLE = 3'd2,
    ST_H_SETTLE = 3'd3,
    ST_H_STABLE = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_Q    = 2'b01;
  localparam logic [1:0] ERR_COMP = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;

  // Bits needed to represent the value SETTLE (at least one bit).
  function automatic int settle_cnt_w(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer
//   Loadable down-counter that measures the propagation window the latch
//   is given after a relevant input change.
//   Ports:
//     clk      : sampling clock, rising edge
//     rst      : asynchronous active-high reset (count -> 0)
//     load     : reload the counter with load_val this cycle
//     load_val : reload value (number of settle cycles)
//     done     : the count reaches zero on the coming clock edge
module settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Flagged one cycle early so the owner can switch state on the same edge
  // the counter hits zero: a load of N yields exactly N settle cycles.
  assign done = (r_count == W'(1));

endmodule

// File: rtl/latch_behavior_monitor.sv
// latch_behavior_monitor
//   Observes a clocked D-latch (gate en, data d, outputs q/q_bar) on a fast
//   sampling clock and pulses err whenever the outputs disagree with ideal
//   latch behaviour once the allowed settle window has elapsed.
//   Ports:
//     clk       : sampling clock, rising edge
//     rst       : asynchronous active-high reset
//     en        : latch gate, 1 = transparent
//     d         : latch data input
//     q, q_bar  : latch outputs under test
//     err       : one-cycle pulse, first mismatch of a stable interval
//     err_code  : cause while err=1 (01 q wrong, 10 q_bar!=~q, 11 both)
//     err_count : number of err pulses, saturating
//     held      : value the latch must currently hold/pass
//     state     : FSM state for debug
module latch_behavior_monitor
  import latch_mon_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  input  logic             q_bar,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic             held,
  output logic [2:0]       state
);

  localparam int CW = settle_cnt_w(SETTLE);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_en_d;
  logic             r_d_d;
  logic             r_held;
  logic             r_armed;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_err_count;

  logic w_en_rise;
  logic w_en_fall;
  logic w_d_chg;
  logic w_done;
  logic w_load;
  logic w_check;
  logic w_exp_q;
  logic w_q_bad;
  logic w_comp_bad;
  logic w_mis;
  logic w_fire;

  assign w_en_rise = en & ~r_en_d;
  assign w_en_fall = ~en & r_en_d;
  assign w_d_chg   = d ^ r_d_d;

  settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (CW'(SETTLE)),
    .done     (w_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNKNOWN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; gate edges win over a same-cycle data change.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_UNKNOWN: begin
        if (en) w_next_state = ST_T_SETTLE;
      end
      ST_T_SETTLE: begin
        if (w_en_fall)    w_next_state = ST_H_SETTLE;
        else if (w_d_chg) w_next_state = ST_T_SETTLE;
        else if (w_done)  w_next_state = ST_T_STABLE;
      end
      ST_T_STABLE: begin
        if (w_en_fall)    w_next_state = ST_H_SETTLE;
        else if (w_d_chg) w_next_state = ST_T_SETTLE;
      end
      ST_H_SETTLE: begin
        if (w_en_rise)   w_next_state = ST_T_SETTLE;
        else if (w_done) w_next_state = ST_H_STABLE;
      end
      ST_H_STABLE: begin
        if (w_en_rise) w_next_state = ST_T_SETTLE;
      end
      default: w_next_state = ST_UNKNOWN;
    endcase
  end

  // Output / control logic
  always_comb begin
    // Reload on every entry to a settle state, and on a data change that
    // keeps the transparent phase settling.
    w_load = ((w_next_state == ST_T_SETTLE) || (w_next_state == ST_H_SETTLE)) &&
             ((w_next_state != r_state) || ((r_state == ST_T_SETTLE) && w_d_chg));
    // A sample that is itself a relevant change is not checked: its effect
    // on q is still inside the new settle window.
    w_check    = ((r_state == ST_T_STABLE) || (r_state == ST_H_STABLE)) &&
                 (w_next_state == r_state);
    w_exp_q    = (r_state == ST_T_STABLE) ? d : r_held;
    w_q_bad    = w_check && (q != w_exp_q);
    w_comp_bad = w_check && (q_bar == q);
    w_mis      = w_q_bad || w_comp_bad;
    w_fire     = w_mis && r_armed;
  end

  // Delayed copies, held value, arming and error reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_d      <= 1'b0;
      r_d_d       <= 1'b0;
      r_held      <= 1'b0;
      r_armed     <= 1'b1;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_count <= '0;
    end else begin
      r_en_d <= en;
      r_d_d  <= d;
      if (en) r_held <= d;
      if (w_load)     r_armed <= 1'b1;
      else if (w_mis) r_armed <= 1'b0;
      r_err      <= w_fire;
      r_err_code <= w_fire ? {w_comp_bad, w_q_bad} : ERR_NONE;
      if (w_fire && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err       = r_err;
  assign err_code  = r_err_code;
  assign err_count = r_err_count;
  assign held      = r_held;
  assign state     = r_state;

endmodule

// File: tb/tb_latch_behavior_monitor.sv
module tb_latch_behavior_monitor;

  localparam int SETTLE = 4;
  localparam int CNT_W  = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             en = 1'b0;
  logic             d = 1'b0;
  logic             q = 1'b0;
  logic             q_bar = 1'b1;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] err_count;
  logic             held;
  logic [2:0]       state;

  latch_behavior_monitor #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d         (d),
    .q         (q),
    .q_bar     (q_bar),
    .err       (err),
    .err_code  (err_code),
    .err_count (err_count),
    .held      (held),
    .state     (state)
  );

  int checks = 0;
  int errors = 0;

  // Observed pulse bookkeeping for phase-level expectations.
  int         pulses = 0;
  logic [1:0] last_code = 2'b00;

  // ---------------- reference model ----------------
  // Event-window view: a relevant event (gate change, or data change while
  // transparent) at cycle N makes cycles N+1..N+SETTLE a settle window and
  // N+SETTLE+1 onward stable, of the phase the gate had at N.
  int   m_cyc;
  int   m_last_ev;
  bit   m_ev_en;
  bit   m_armed;
  bit   m_held;
  bit   m_p_en;
  bit   m_p_d;
  int   m_count;
  logic [31:0] exp_q[$];  // pending expected err_code, one per sampled cycle

  function automatic int state_at(input int c);
    int delta;
    if (m_last_ev < 0) return 0;
    delta = c - m_last_ev;
    if (delta <= SETTLE) return m_ev_en ? 1 : 3;
    return m_ev_en ? 2 : 4;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_last_ev = -1; m_ev_en = 0; m_armed = 1;
    m_held = 0; m_p_en = 0; m_p_d = 0; m_count = 0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one sampled cycle ----------------
  task automatic cyc(input bit e, input bit dd, input bit qq, input bit qqb);
    int   cur;
    bit   ev, expq, mis, fire;
    logic [31:0] code;
    en = e; d = dd; q = qq; q_bar = qqb;
    cur  = state_at(m_cyc);
    ev   = (e != m_p_en) || (e && (dd != m_p_d));
    expq = (cur == 2) ? dd : m_held;
    mis  = ((cur == 2) || (cur == 4)) && !ev && ((qq != expq) || (qqb == qq));
    fire = mis && m_armed;
    code = fire ? {30'd0, (qqb == qq), (qq != expq)} : 32'd0;
    exp_q.push_back(code);
    if (ev) begin
      m_last_ev = m_cyc; m_ev_en = e; m_armed = 1;
    end else if (mis) begin
      m_armed = 0;
    end
    if (fire && m_count < MAXC) m_count++;
    if (e) m_held = dd;
    m_p_en = e; m_p_d = dd; m_cyc++;
    @(posedge clk); #1;
    code = exp_q.pop_front();
    chk("state", 32'(state), 32'(state_at(m_cyc)));
    chk("err", 32'(err), 32'(code != 0));
    chk("err_code", 32'(err_code), code);
    chk("err_count", 32'(err_count), 32'(m_count));
    chk("held", 32'(held), 32'(m_held));
    if (err === 1'b1) begin
      pulses++;
      last_code = err_code;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit re, rd, ideal, rq, rqb;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    rst = 1'b0;

    // 1: en=1, d=1, correct outputs arrive 3 cycles later: no err,
    //    T_STABLE 5 cycles after the gate rises.
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, (i >= 3), (i < 3));
      if (i == 3) chk("t_settle_at_4", 32'(state), 32'd1);
      if (i == 4) chk("t_stable_at_5", 32'(state), 32'd2);
    end
    chk("p1_pulses", 32'(pulses), 32'd0);

    // 2: q forced low for 10 cycles in T_STABLE: one pulse, code 01.
    pulses = 0;
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    chk("p2_pulses", 32'(pulses), 32'd1);
    chk("p2_code", 32'(last_code), 32'd1);
    chk("p2_count", 32'(err_count), 32'd1);

    // 3: gate drops with held=1, d toggles every 2 cycles, q stays 1.
    pulses = 0;
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(0, ((i / 2) % 2) == 1, 1, 0);
      chk("p3_held", 32'(held), 32'd1);
    end
    chk("p3_state", 32'(state), 32'd4);
    chk("p3_pulses", 32'(pulses), 32'd0);

    // 4: complement fault in H_STABLE (code 10), re-arm, then both (code 11).
    pulses = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);
    chk("p4_comp_pulses", 32'(pulses), 32'd1);
    chk("p4_comp_code", 32'(last_code), 32'd2);
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("p4_both_pulses", 32'(pulses), 32'd2);
    chk("p4_both_code", 32'(last_code), 32'd3);
    chk("p4_count", 32'(err_count), 32'd3);

    // 5: d toggles every 3 cycles while transparent: never leaves T_SETTLE.
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(1, ((i / 3) % 2) == 1, 0, 0);
      chk("p5_state", 32'(state), 32'd1);
    end
    chk("p5_pulses", 32'(pulses), 32'd0);

    // 6: two more violation intervals: pulses continue, count saturated.
    pulses = 0;
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0);
    chk("p6_pulses", 32'(pulses), 32'd2);
    chk("p6_count_sat", 32'(err_count), 32'(MAXC));

    // 7: randomized traffic against the model.
    re = 1; rd = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9, 0) == 0) re = ~re;
      if ($urandom_range(3, 0) == 0) rd = ~rd;
      ideal = re ? rd : m_held;
      rq  = ($urandom_range(7, 0) == 0) ? ~ideal : ideal;
      rqb = ($urandom_range(7, 0) == 0) ? rq : ~rq;
      cyc(re, rd, rq, rqb);
    end

    // 8: asynchronous reset two cycles into T_SETTLE.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("p8_pre_state", 32'(state), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("p8_async_state", 32'(state), 32'd0);
    chk("p8_async_err", 32'(err), 32'd0);
    chk("p8_async_code", 32'(err_code), 32'd0);
    chk("p8_async_count", 32'(err_count), 32'd0);
    chk("p8_async_held", 32'(held), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("p8_in_rst_err", 32'(err), 32'd0);
    chk("p8_in_rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, (i % 2) == 1, i % 2 == 0, 1);
      chk("p8_unknown", 32'(state), 32'd0);
    end
    cyc(1, 1, 1, 0);
    chk("p8_leave_unknown", 32'(state), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
